// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU and load writebacks
// onto one write port and tracks pending destinations in a scoreboard.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   alu_valid/alu_rd/alu_data      ALU writeback request
//   alu_ready                      ALU grant (combinational)
//   mem_valid/mem_rd/mem_data      load writeback request
//   mem_ready                      load grant (combinational)
//   issue_valid/issue_rd           reserve a destination in the scoreboard
//   flush                          clear scoreboard and starvation state
//   busy_mask                      per-register pending-write flags
//   regWrite/writeRegister/writeData  register-file write port (registered)
module regfile_write_scheduler #(
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                regWrite,
    output logic [ADDR_W-1:0]   writeRegister,
    output logic [DATA_W-1:0]   writeData
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0]       alu_wait_q, alu_wait_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                starve;
    logic                alu_hs, mem_hs, hs;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_ok;

    assign starve = (alu_wait_q == WW'(STARVE_LIMIT));

    // Grants are gated by reset so neither requester sees a
    // transfer while the block is held in reset.
    assign mem_ready = !reset && mem_valid && !(starve && alu_valid);
    assign alu_ready = !reset && alu_valid && (!mem_valid || starve);

    assign alu_hs = alu_valid && alu_ready;
    assign mem_hs = mem_valid && mem_ready;
    assign hs     = alu_hs || mem_hs;

    assign sel_rd   = alu_hs ? alu_rd : mem_rd;
    assign sel_data = alu_hs ? alu_data : mem_data;

    // Only implemented, non-zero registers reach the register file.
    always_comb begin
        sel_ok = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (sel_rd == ADDR_W'(i)) sel_ok = 1'b1;
        end
    end

    always_comb begin
        alu_wait_d = '0;
        if (!flush && alu_valid && !alu_ready) begin
            if (alu_wait_q == WW'(STARVE_LIMIT))
                alu_wait_d = alu_wait_q;
            else
                alu_wait_d = alu_wait_q + WW'(1);
        end
    end

    always_comb begin
        wr_en_d   = hs && sel_ok;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (hs && sel_ok) begin
            wr_rd_d   = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Clear first, then set, so a new producer issued in the same
    // cycle as the old one retires keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (hs && sel_rd == ADDR_W'(i)) busy_d[i] = 1'b0;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_valid && issue_rd == ADDR_W'(i)) busy_d[i] = 1'b1;
        end
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_wait_q <= '0;
            busy_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_rd_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            alu_wait_q <= alu_wait_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy_mask     = busy_q;
    assign regWrite      = wr_en_q;
    assign writeRegister = wr_rd_q;
    assign writeData     = wr_data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed testbench for regfile_write_scheduler.
// Inputs change on the falling edge; outputs are sampled away from rising edges.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [15:0] busy_mask;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData)
    );

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #2;
        n_checks++;
        if ({regWrite, writeRegister, writeData} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_wport got %b/%0d/%h want 0/0/0",
                     regWrite, writeRegister, writeData);
        end
        n_checks++;
        if (busy_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_busy got %h want 0000", busy_mask);
        end
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 00", {alu_ready, mem_ready});
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_contention();
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h11;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL alu_alone_ready got %b want 10", {alu_ready, mem_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd5, 32'h11}) begin
            n_fail++;
            $display("FAIL alu_alone_write got %b/%0d/%h want 1/5/11",
                     regWrite, writeRegister, writeData);
        end
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 6; mem_data = 32'h22;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mem_alone_ready got %b want 01", {alu_ready, mem_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd6, 32'h22}) begin
            n_fail++;
            $display("FAIL mem_alone_write got %b/%0d/%h want 1/6/22",
                     regWrite, writeRegister, writeData);
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 5'd6, 32'h22}) begin
            n_fail++;
            $display("FAIL idle_hold got %b/%0d/%h want 0/6/22",
                     regWrite, writeRegister, writeData);
        end
    endtask

    task automatic test_contention();
        logic       exp_alu;
        logic [4:0] exp_rd;
        alu_valid = 1'b1; alu_rd = 3; alu_data = 32'hAA;
        mem_valid = 1'b1; mem_rd = 4; mem_data = 32'hBB;
        // Cycle 5 re-checks memory priority after the ALU wait counter clears.
        for (int c = 1; c <= 5; c++) begin
            exp_alu = (c == 4);
            exp_rd  = exp_alu ? 5'd3 : 5'd4;
            #1;
            n_checks++;
            if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu}) begin
                n_fail++;
                $display("FAIL contend_ready c%0d got %b want %b", c,
                         {alu_ready, mem_ready}, {exp_alu, !exp_alu});
            end
            @(negedge clk);
            n_checks++;
            if ({regWrite, writeRegister} !== {1'b1, exp_rd}) begin
                n_fail++;
                $display("FAIL contend_write c%0d got %b/%0d want 1/%0d", c,
                         regWrite, writeRegister, exp_rd);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 7;
        @(negedge clk);
        issue_valid = 1'b0;
        n_checks++;
        if (busy_mask !== 16'h0080) begin
            n_fail++;
            $display("FAIL sb_set got %h want 0080", busy_mask);
        end
        mem_valid = 1'b1; mem_rd = 7; mem_data = 32'h77;
        @(negedge clk);
        n_checks++;
        if ({regWrite, writeRegister, busy_mask} !== {1'b1, 5'd7, 16'h0}) begin
            n_fail++;
            $display("FAIL sb_clear got %b/%0d/%h want 1/7/0000",
                     regWrite, writeRegister, busy_mask);
        end
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 7;
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 7; mem_data = 32'h78;
        @(negedge clk);
        n_checks++;
        if ({regWrite, writeData, busy_mask} !== {1'b1, 32'h78, 16'h0080}) begin
            n_fail++;
            $display("FAIL sb_set_wins got %b/%h/%h want 1/78/0080",
                     regWrite, writeData, busy_mask);
        end
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 7; mem_data = 32'h79;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (busy_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL sb_reclear got %h want 0000", busy_mask);
        end
    endtask

    task automatic test_x0_range();
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hDEAD;
        issue_valid = 1'b1; issue_rd = 0;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready got %b want 1", alu_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({regWrite, busy_mask} !== {1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL x0_write got %b/%h want 0/0000", regWrite, busy_mask);
        end
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 20;
        mem_valid = 1'b1; mem_rd = 20; mem_data = 32'h1;
        #1;
        n_checks++;
        if (mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_ready got %b want 1", mem_ready);
        end
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if ({regWrite, busy_mask} !== {1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL oor_write got %b/%h want 0/0000", regWrite, busy_mask);
        end
    endtask

    task automatic test_flush();
        for (int r = 4; r <= 7; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            @(negedge clk);
        end
        idle_inputs();
        n_checks++;
        if (busy_mask !== 16'h00F0) begin
            n_fail++;
            $display("FAIL flush_pre got %h want 00f0", busy_mask);
        end
        flush = 1'b1;
        alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h5;
        issue_valid = 1'b1; issue_rd = 2;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready got %b want 1", alu_ready);
        end
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if ({regWrite, writeRegister, writeData, busy_mask} !==
            {1'b1, 5'd9, 32'h5, 16'h0}) begin
            n_fail++;
            $display("FAIL flush_post got %b/%0d/%h/%h want 1/9/5/0000",
                     regWrite, writeRegister, writeData, busy_mask);
        end
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1; issue_rd = 11;
        @(negedge clk);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 10; alu_data = 32'hCAFE;
        @(posedge clk);
        #2;
        n_checks++;
        if ({regWrite, writeRegister, busy_mask} !== {1'b1, 5'd10, 16'h0800}) begin
            n_fail++;
            $display("FAIL arst_pre got %b/%0d/%h want 1/10/0800",
                     regWrite, writeRegister, busy_mask);
        end
        mem_valid = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({regWrite, writeRegister, writeData, busy_mask} !== 54'd0) begin
            n_fail++;
            $display("FAIL arst_state got %b/%0d/%h/%h want 0/0/0/0000",
                     regWrite, writeRegister, writeData, busy_mask);
        end
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_ready got %b want 00", {alu_ready, mem_ready});
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_no_contention();
        test_contention();
        test_scoreboard();
        test_x0_range();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU/execute path and the load (memory) unit.
- Drives the `regWrite` / `writeRegister` / `writeData` inputs of the 16-entry register file.
- Keeps a busy-register scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REGS, 16, number of architectural registers implemented (entries 0..NUM_REGS-1).
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- STARVE_LIMIT, 3, consecutive blocked ALU cycles before the ALU takes priority over memory.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request granted this cycle.
- issue_valid  in  1  decode issued an instruction that will write issue_rd.
- issue_rd  in  ADDR_W  destination to reserve.
- flush  in  1  pipeline flush: clears scoreboard and arbitration state.
- busy_mask  out  NUM_REGS  bit i = register i has a pending write.
- regWrite  out  1  register-file write enable.
- writeRegister  out  ADDR_W  register-file write address.
- writeData  out  DATA_W  register-file write data.

Behaviour:
- Reset (async, active-high), all outputs at 0:
  - regWrite=0, writeRegister=0, writeData=0, busy_mask=0.
  - alu_ready=0 and mem_ready=0 while reset is asserted.
  - Starvation counter = 0.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - The requester holds valid, rd and data stable until ready.
  - ready is a combinational grant that depends on both valids. It is never asserted without the matching valid.
- Arbitration, at most one grant per cycle:
  - starve = (alu_wait == STARVE_LIMIT).
  - mem_ready = mem_valid && !(starve && alu_valid).
  - alu_ready = alu_valid && (!mem_valid || starve).
- Starvation counter alu_wait, 0..STARVE_LIMIT:
  - Increments, saturating, on a cycle where alu_valid && !alu_ready.
  - Clears on an ALU handshake or when alu_valid=0.
- Write port, registered, latency 1:
  - On a handshake at edge N, regWrite=1 in cycle N+1, with writeRegister/writeData = granted rd/data.
  - Otherwise regWrite=0; writeRegister/writeData hold their last values.
- Address filtering:
  - A granted request with rd==0 or rd>=NUM_REGS is accepted (ready asserted) but produces regWrite=0.
  - The register file never sees a write to x0 or an unimplemented index.
- Scoreboard, busy_mask registered:
  - Set: issue_valid with issue_rd in 1..NUM_REGS-1 sets bit issue_rd at the next edge. rd 0 or out of range is ignored.
  - Clear: a handshake on rd clears bit rd at the next edge, so the bit drops in the same cycle regWrite is asserted.
  - Same register set and cleared in one cycle: set wins (newer producer pending).
  - Clearing a bit that is already 0 is harmless.
- Flush (synchronous):
  - At the next edge: busy_mask=0, alu_wait=0, and issue_valid that cycle is ignored.
  - A handshake in the flush cycle still completes: regWrite is asserted in the next cycle. Flush never cancels a granted write.
  - Ready outputs are unaffected by flush.
- Reset mid-operation: a pending registered write is discarded immediately (regWrite forced 0 asynchronously).
- No internal buffering. A stalled requester simply waits, and throughput is one write per cycle.

Test Plan:
- Both requests, no contention:
  - alu_valid, rd=5, data=0x11 alone → alu_ready=1, next cycle regWrite=1, writeRegister=5, writeData=0x11.
  - Then mem_valid, rd=6, data=0x22 → same on rd 6.
- Contention priority:
  - alu (rd=3, 0xAA) and mem (rd=4, 0xBB) both held valid.
  - Expected grants: mem for 3 cycles (mem_ready=1, alu_ready=0), then alu on cycle 4 (alu_ready=1, mem_ready=0).
  - Expected writes, one cycle later each: rd4 on cycles 2-4, rd3 on cycle 5.
  - alu_wait returns to 0 after the ALU grant.
- Scoreboard:
  - issue_valid rd=7 → busy_mask[7]=1 next cycle.
  - mem writes rd 7 → busy_mask[7]=0 in the same cycle regWrite=1.
  - Same cycle issue rd=7 and handshake rd=7 → busy_mask[7] stays 1.
- x0 / out of range:
  - ALU grant with rd=0 → alu_ready=1, regWrite stays 0.
  - issue_rd=0 and issue_rd=20 → busy_mask unchanged.
- Flush:
  - busy_mask=0x00F0, flush=1 with a concurrent ALU grant rd=9, data=0x5 → next cycle busy_mask=0 and regWrite=1, writeRegister=9, writeData=0x5.
- Async reset:
  - Assert reset between edges while a write is pending → regWrite, writeRegister, writeData, busy_mask and both readies go to 0 immediately, without waiting for a clk edge.
